// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Fetch/decode/execute/mem/writeback sequencer for the 8-bit core,
//            with a request/ack memory handshake guarded by a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       eq,
  input  logic       mem_ack,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic       alu_en,
  output logic       reg_we,
  output logic [1:0] reg_src,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(MEM_TIMEOUT);

  localparam logic [2:0] c_op_r   = 3'b000;
  localparam logic [2:0] c_op_mfi = 3'b001;
  localparam logic [2:0] c_op_mw  = 3'b010;
  localparam logic [2:0] c_op_mr  = 3'b011;
  localparam logic [2:0] c_op_j   = 3'b100;
  localparam logic [2:0] c_op_jce = 3'b101;
  localparam logic [2:0] c_op_mb  = 3'b110;
  localparam logic [2:0] c_op_jcn = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t               r_state;
  logic [2:0]           r_op;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic                 w_timeout;
  state_t               w_end_state;

  assign w_cnt_inc   = r_cnt + c_cnt_w'(1);
  assign w_timeout   = (w_cnt_inc == c_cnt_lim);
  assign w_end_state = run ? S_FETCH : S_IDLE;

  // The counter is held at zero outside FETCH/MEM and cleared on ack, so every
  // entry into a request state starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 3'b000;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack)        r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_FAULT;
          else                r_cnt   <= w_cnt_inc;
        end
        S_DECODE: begin
          r_op <= opcode;
          case (opcode)
            c_op_mfi, c_op_mb: r_state <= S_WB;
            c_op_mw, c_op_mr:  r_state <= S_MEM;
            default:           r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_state <= (r_op == c_op_r) ? S_WB : w_end_state;
        end
        S_MEM: begin
          if (mem_ack)        r_state <= (r_op == c_op_mr) ? S_WB : w_end_state;
          else if (w_timeout) r_state <= S_FAULT;
          else                r_cnt   <= w_cnt_inc;
        end
        S_WB: begin
          r_state <= w_end_state;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  always_comb begin
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    alu_en  = 1'b0;
    reg_we  = 1'b0;
    reg_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      S_EXEC: begin
        case (r_op)
          c_op_r:   alu_en  = 1'b1;
          c_op_j:   pc_load = 1'b1;
          c_op_jce: pc_load = eq;
          c_op_jcn: pc_load = ~eq;
          default:  pc_load = 1'b0;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_op == c_op_mw);
      end
      S_WB: begin
        reg_we = 1'b1;
        case (r_op)
          c_op_mfi: reg_src = 2'b01;
          c_op_mr:  reg_src = 2'b10;
          c_op_mb:  reg_src = 2'b11;
          default:  reg_src = 2'b00;
        endcase
      end
      default: begin
        reg_src = 2'b00;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault = (r_state == S_FAULT);
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Scoreboard bench for instr_sequencer, cycle-by-cycle output check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int TMO = 4;
  localparam logic [6:0] IR = 7'b1000000, PI = 7'b0100000, PL = 7'b0010000,
                         RQ = 7'b0001000, WE = 7'b0000100, AL = 7'b0000010,
                         RW = 7'b0000001, NO = 7'b0000000;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, eq = 1'b0, mem_ack = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic ir_load, pc_inc, pc_load, mem_req, mem_we, alu_en, reg_we, busy, fault;
  logic [1:0] reg_src;
  logic [2:0] state;
  logic [13:0] obs;
  logic [13:0] exp_v;
  logic [13:0] sb[$];
  int checks = 0, failures = 0;

  instr_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clk), .reset(rst), .run(run), .opcode(opcode), .eq(eq), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req),
    .mem_we(mem_we), .alu_en(alu_en), .reg_we(reg_we), .reg_src(reg_src),
    .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, ir_load, pc_inc, pc_load, mem_req, mem_we, alu_en, reg_we,
                reg_src, busy, fault};

  typedef struct packed {
    logic r; logic a; logic e; logic [2:0] o;
    logic [2:0] st; logic [6:0] stb; logic [1:0] src;
  } step_t;

  // Expected vector: busy and fault follow from the state the bench expects.
  function automatic logic [13:0] ev(input logic [2:0] st, input logic [6:0] stb,
                                     input logic [1:0] src);
    return {st, stb, src, (st != 3'd0 && st != 3'd6), (st == 3'd6)};
  endfunction

  function automatic step_t s(input logic r, input logic a, input logic e,
                              input logic [2:0] o, input logic [2:0] st,
                              input logic [6:0] stb, input logic [1:0] src);
    step_t t;
    t.r = r; t.a = a; t.e = e; t.o = o; t.st = st; t.stb = stb; t.src = src;
    return t;
  endfunction

  // Applies one cycle of stimulus, records its expectation, waits for sampling.
  task automatic drive(input step_t t);
    run = t.r; mem_ack = t.a; eq = t.e; opcode = t.o;
    sb.push_back(ev(t.st, t.stb, t.src));
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t t[$];
    run = 1'b1; mem_ack = 1'b1;
    sb.push_back(ev(3'd0, NO, 2'b00));
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_held got=%b exp=%b", obs, exp_v);
    end
    advance();
    rst = 1'b0;
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL reset_idle[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_r_loop();
    step_t t[$];
    t.push_back(s(1,1,0,3'd0, 3'd0, NO, 2'b00));
    for (int k = 0; k < 2; k++) begin
      t.push_back(s(1,1,0,3'd0, 3'd1, IR|PI|RQ, 2'b00));
      t.push_back(s(1,1,0,3'd0, 3'd2, NO, 2'b00));
      t.push_back(s(1,1,1,3'd0, 3'd3, AL, 2'b00));
      t.push_back(s(k == 0, 1,0,3'd0, 3'd5, RW, 2'b00));
    end
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL r_loop[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_mem_ops();
    step_t t[$];
    // MR with two wait cycles, then MW back to back with zero-wait memory
    t.push_back(s(1,0,0,3'd3, 3'd0, NO, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd2, NO, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd4, RQ, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd4, RQ, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd4, RQ, 2'b00));
    t.push_back(s(1,0,0,3'd2, 3'd5, RW, 2'b10));
    t.push_back(s(1,1,0,3'd2, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd2, 3'd2, NO, 2'b00));
    t.push_back(s(0,1,0,3'd2, 3'd4, RQ|WE, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mem_ops[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_writeback();
    step_t t[$];
    t.push_back(s(1,0,0,3'd1, 3'd0, NO, 2'b00));
    t.push_back(s(1,1,0,3'd1, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd1, 3'd2, NO, 2'b00));
    t.push_back(s(1,0,0,3'd1, 3'd5, RW, 2'b01));
    t.push_back(s(1,1,0,3'd6, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd6, 3'd2, NO, 2'b00));
    t.push_back(s(0,0,0,3'd6, 3'd5, RW, 2'b11));
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL writeback[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    logic [2:0] ops[6] = '{3'd5, 3'd5, 3'd7, 3'd7, 3'd4, 3'd4};
    logic       eqs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tak[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t.push_back(s(1,0,0,3'd0, 3'd0, NO, 2'b00));
    for (int k = 0; k < 6; k++) begin
      t.push_back(s(1,1,~eqs[k],ops[k], 3'd1, IR|PI|RQ, 2'b00));
      t.push_back(s(1,0,~eqs[k],ops[k], 3'd2, NO, 2'b00));
      t.push_back(s(k != 5, 0,eqs[k],ops[k], 3'd3, tak[k] ? PL : NO, 2'b00));
    end
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL branch[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_run_drop();
    step_t t[$];
    t.push_back(s(1,0,0,3'd0, 3'd0, NO, 2'b00));
    t.push_back(s(1,1,0,3'd0, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd2, NO, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd3, AL, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd5, RW, 2'b00));
    t.push_back(s(0,1,0,3'd0, 3'd0, NO, 2'b00));
    t.push_back(s(0,1,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL run_drop[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_ack_at_limit();
    step_t t[$];
    t.push_back(s(1,0,0,3'd4, 3'd0, NO, 2'b00));
    for (int k = 1; k < TMO; k++) t.push_back(s(1,0,0,3'd4, 3'd1, RQ, 2'b00));
    t.push_back(s(1,1,0,3'd4, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd4, 3'd2, NO, 2'b00));
    t.push_back(s(0,0,0,3'd4, 3'd3, PL, 2'b00));
    t.push_back(s(0,0,0,3'd0, 3'd0, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL ack_at_limit[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_fetch_timeout();
    step_t t[$];
    t.push_back(s(1,0,0,3'd0, 3'd0, NO, 2'b00));
    for (int k = 0; k < TMO; k++) t.push_back(s(1,0,0,3'd0, 3'd1, RQ, 2'b00));
    t.push_back(s(1,1,0,3'd0, 3'd6, NO, 2'b00));
    t.push_back(s(0,1,1,3'd0, 3'd6, NO, 2'b00));
    t.push_back(s(1,1,0,3'd0, 3'd6, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL fetch_timeout[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
    do_reset();
  endtask

  task automatic test_mem_timeout();
    step_t t[$];
    // FETCH waits first, so a counter not cleared on MEM entry faults early
    t.push_back(s(1,0,0,3'd3, 3'd0, NO, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd1, RQ, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd1, RQ, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd2, NO, 2'b00));
    for (int k = 0; k < TMO; k++) t.push_back(s(1,0,0,3'd3, 3'd4, RQ, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd6, NO, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd6, NO, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mem_timeout[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      advance();
    end
    do_reset();
  endtask

  task automatic test_reset_in_mem();
    step_t t[$];
    t.push_back(s(1,0,0,3'd3, 3'd0, NO, 2'b00));
    t.push_back(s(1,1,0,3'd3, 3'd1, IR|PI|RQ, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd2, NO, 2'b00));
    t.push_back(s(1,0,0,3'd3, 3'd4, RQ, 2'b00));
    foreach (t[i]) begin
      drive(t[i]);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL reset_in_mem[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      if (i != t.size() - 1) advance();
    end
    // Assert reset between edges: outputs must drop before any clock edge
    #2;
    rst = 1'b1;
    sb.push_back(ev(3'd0, NO, 2'b00));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", obs, exp_v);
    end
    advance();
    rst = 1'b0; run = 1'b0; mem_ack = 1'b0;
    sb.push_back(ev(3'd0, NO, 2'b00));
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", obs, exp_v);
    end
    advance();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_r_loop();
    test_mem_ops();
    test_writeback();
    test_branch();
    test_run_drop();
    test_ack_at_limit();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_in_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
